// File: rtl/aster_pkg.sv
// Shared types and the default asteroid spawn layout for the AstroGenius spawn-table memory.
// Fields are packed as {x, y, dir} with x in the most significant bits.
package aster_pkg;

  localparam int X_BITS_DEF   = 4;
  localparam int Y_BITS_DEF   = 4;
  localparam int DIR_BITS_DEF = 2;
  localparam int DATA_W_DEF   = X_BITS_DEF + Y_BITS_DEF + DIR_BITS_DEF;

  typedef enum logic {ST_INIT, ST_IDLE} state_e;

  typedef struct packed {
    logic [X_BITS_DEF-1:0]   x;
    logic [Y_BITS_DEF-1:0]   y;
    logic [DIR_BITS_DEF-1:0] dir;
  } aster_t;

  function automatic logic [DATA_W_DEF-1:0] pack_aster(input aster_t a);
    return a;
  endfunction

  function automatic aster_t unpack_aster(input logic [DATA_W_DEF-1:0] d);
    return aster_t'(d);
  endfunction

  // Reference layout in the 4/4/2 field format; the table repeats every 16 entries.
  function automatic logic [9:0] default_raw(input int i);
    logic [9:0] v;
    case (i % 16)
      3, 12, 13: v = 10'h01C;
      4:         v = 10'h1C0;
      5, 7:      v = 10'h39D;
      9:         v = 10'h1DC;
      10, 11:    v = 10'h1C2;
      default:   v = 10'h1FB;
    endcase
    return v;
  endfunction

  // Re-packs the reference entry into arbitrary field widths, zero-extending or truncating each field.
  function automatic logic [63:0] default_entry(input int i, input int xb, input int yb, input int db);
    logic [9:0]  raw;
    logic [63:0] x, y, d;
    raw = default_raw(i);
    x   = 64'(raw[9:6]) & ((64'd1 << xb) - 64'd1);
    y   = 64'(raw[5:2]) & ((64'd1 << yb) - 64'd1);
    d   = 64'(raw[1:0]) & ((64'd1 << db) - 64'd1);
    return (x << (yb + db)) | (y << db) | d;
  endfunction

endpackage

// File: rtl/aster_ram.sv
// Spawn-table storage: one write port, a write-first registered-address read port and a
// read-before-write synchronous read port used by the sequencer.
module aster_ram #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_q,
  input  logic              seq_re,
  input  logic [ADDR_W-1:0] seq_addr,
  output logic [DATA_W-1:0] seq_q
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] r_addr_q;

  // NOTE: the array has no reset so it maps onto RAM macros; contents come from the init sweep instead.
  always_ff @(posedge clk) begin
    if (we) mem_q[w_addr] <= w_data;
  end

  always_ff @(posedge clk) begin
    r_addr_q <= r_addr;
  end

  // Reading through the registered address makes a same-edge write visible immediately.
  assign r_q = mem_q[r_addr_q];

  // NOTE: non-blocking assignment samples mem_q before this edge's write lands, giving old data.
  always_ff @(posedge clk) begin
    if (reset)       seq_q <= '0;
    else if (seq_re) seq_q <= mem_q[seq_addr];
  end

endmodule

// File: rtl/memoria_aster_seq.sv
// Asteroid spawn-table memory with an init sweep restoring the default layout and a
// request-driven sequencer that walks the table up to a programmable wrap index.
module memoria_aster_seq
  import aster_pkg::*;
#(
  parameter int X_BITS   = X_BITS_DEF,
  parameter int Y_BITS   = Y_BITS_DEF,
  parameter int DIR_BITS = DIR_BITS_DEF,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               we,
  input  logic [ADDR_W-1:0]                  w_addr,
  input  logic [X_BITS+Y_BITS+DIR_BITS-1:0]  w_data,
  input  logic [ADDR_W-1:0]                  r_addr,
  output logic [X_BITS+Y_BITS+DIR_BITS-1:0]  r_q,
  input  logic                               prox,
  input  logic [ADDR_W-1:0]                  limite,
  output logic [X_BITS+Y_BITS+DIR_BITS-1:0]  seq_q,
  output logic [ADDR_W-1:0]                  seq_idx,
  output logic                               seq_valid,
  output logic                               fim_ciclo,
  output logic                               ocupado
);

  localparam int DATA_W = X_BITS + Y_BITS + DIR_BITS;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] init_ptr_q, seq_ptr_q, seq_ptr_d, seq_idx_q, eff_limite;
  logic              seq_valid_q, fim_ciclo_q, ocupado_q;
  logic              ram_we, seq_re;
  logic [ADDR_W-1:0] ram_w_addr;
  logic [DATA_W-1:0] ram_w_data, ram_r_q, def_word;

  assign def_word = DATA_W'(default_entry(int'(init_ptr_q) % 16, X_BITS, Y_BITS, DIR_BITS));

  always_comb begin
    eff_limite = limite;
    if (int'(limite) >= DEPTH) eff_limite = LAST;
    // Wrapping at LAST as well keeps a lowered limite from running the pointer off the table.
    seq_ptr_d = seq_ptr_q + 1'b1;
    if (seq_ptr_q == eff_limite || seq_ptr_q == LAST) seq_ptr_d = '0;
  end

  always_comb begin
    ram_we     = 1'b0;
    ram_w_addr = w_addr;
    ram_w_data = w_data;
    if (!reset) begin
      if (state_q == ST_INIT) begin
        ram_we     = 1'b1;
        ram_w_addr = init_ptr_q;
        ram_w_data = def_word;
      end else begin
        ram_we = we;
      end
    end
  end

  assign seq_re = !reset && (state_q == ST_IDLE) && prox;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_ptr_q  <= '0;
      seq_ptr_q   <= '0;
      seq_idx_q   <= '0;
      seq_valid_q <= 1'b0;
      fim_ciclo_q <= 1'b0;
      ocupado_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          seq_valid_q <= 1'b0;
          fim_ciclo_q <= 1'b0;
          init_ptr_q  <= init_ptr_q + 1'b1;
          if (init_ptr_q == LAST) begin
            state_q   <= ST_IDLE;
            ocupado_q <= 1'b0;
          end
        end
        default: begin
          seq_valid_q <= prox;
          fim_ciclo_q <= prox && (seq_ptr_q == eff_limite);
          if (prox) begin
            seq_idx_q <= seq_ptr_q;
            seq_ptr_q <= seq_ptr_d;
          end
        end
      endcase
    end
  end

  aster_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (ram_we),
    .w_addr  (ram_w_addr),
    .w_data  (ram_w_data),
    .r_addr  (r_addr),
    .r_q     (ram_r_q),
    .seq_re  (seq_re),
    .seq_addr(seq_ptr_q),
    .seq_q   (seq_q)
  );

  assign r_q       = ocupado_q ? '0 : ram_r_q;
  assign seq_idx   = seq_idx_q;
  assign seq_valid = seq_valid_q;
  assign fim_ciclo = fim_ciclo_q;
  assign ocupado   = ocupado_q;

endmodule

// File: tb/tb_memoria_aster_seq.sv
// Directed bench for memoria_aster_seq: a 16-entry instance plus a 32-entry instance for wrap checks.
module tb_memoria_aster_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       we, prox;
  logic [3:0] w_addr, r_addr, limite;
  logic [9:0] w_data, r_q, seq_q;
  logic [3:0] seq_idx;
  logic       seq_valid, fim_ciclo, ocupado;

  logic       we32, prox32;
  logic [4:0] w_addr32, r_addr32, limite32, seq_idx32;
  logic [9:0] w_data32, r_q32, seq_q32;
  logic       seq_valid32, fim_ciclo32, ocupado32;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] def_tbl [16] = '{10'h1FB, 10'h1FB, 10'h1FB, 10'h01C, 10'h1C0, 10'h39D, 10'h1FB, 10'h39D,
                               10'h1FB, 10'h1DC, 10'h1C2, 10'h1C2, 10'h01C, 10'h01C, 10'h1FB, 10'h1FB};

  always #5 clk = ~clk;

  memoria_aster_seq dut (
    .clk(clk), .reset(reset), .we(we), .w_addr(w_addr), .w_data(w_data),
    .r_addr(r_addr), .r_q(r_q), .prox(prox), .limite(limite),
    .seq_q(seq_q), .seq_idx(seq_idx), .seq_valid(seq_valid),
    .fim_ciclo(fim_ciclo), .ocupado(ocupado)
  );

  memoria_aster_seq #(.DEPTH(32), .ADDR_W(5)) dut32 (
    .clk(clk), .reset(reset), .we(we32), .w_addr(w_addr32), .w_data(w_data32),
    .r_addr(r_addr32), .r_q(r_q32), .prox(prox32), .limite(limite32),
    .seq_q(seq_q32), .seq_idx(seq_idx32), .seq_valid(seq_valid32),
    .fim_ciclo(fim_ciclo32), .ocupado(ocupado32)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++; if (ocupado !== 1'b1)    begin n_err++; $display("FAIL reset_ocupado: got %b want 1", ocupado); end
    n_cmp++; if (seq_valid !== 1'b0)  begin n_err++; $display("FAIL reset_seq_valid: got %b want 0", seq_valid); end
    n_cmp++; if (fim_ciclo !== 1'b0)  begin n_err++; $display("FAIL reset_fim_ciclo: got %b want 0", fim_ciclo); end
    n_cmp++; if (seq_q !== 10'h000)   begin n_err++; $display("FAIL reset_seq_q: got %h want 000", seq_q); end
    n_cmp++; if (seq_idx !== 4'd0)    begin n_err++; $display("FAIL reset_seq_idx: got %0d want 0", seq_idx); end
    n_cmp++; if (r_q !== 10'h000)     begin n_err++; $display("FAIL reset_r_q: got %h want 000", r_q); end
  endtask

  task automatic test_init_sweep();
    int n;
    reset = 1'b0;
    n = 0;
    while (ocupado === 1'b1 && n < 40) begin
      step();
      n++;
    end
    n_cmp++; if (n != 16) begin n_err++; $display("FAIL sweep_cycles: got %0d want 16", n); end
  endtask

  task automatic test_read_defaults();
    logic [3:0] addrs [5] = '{4'd0, 4'd3, 4'd5, 4'd9, 4'd10};
    logic [9:0] exps  [5] = '{10'h1FB, 10'h01C, 10'h39D, 10'h1DC, 10'h1C2};
    for (int i = 0; i < 5; i++) begin
      r_addr = addrs[i];
      step();
      n_cmp++;
      if (r_q !== exps[i]) begin n_err++; $display("FAIL read_default[%0d]: got %h want %h", addrs[i], r_q, exps[i]); end
    end
  endtask

  task automatic test_sequencer();
    logic [3:0] e_idx [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    logic [9:0] e_q   [5] = '{10'h1FB, 10'h1FB, 10'h1FB, 10'h01C, 10'h1FB};
    limite = 4'd3;
    prox   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (seq_valid !== 1'b1)  begin n_err++; $display("FAIL seq_valid[%0d]: got %b want 1", i, seq_valid); end
      n_cmp++; if (seq_idx !== e_idx[i]) begin n_err++; $display("FAIL seq_idx[%0d]: got %0d want %0d", i, seq_idx, e_idx[i]); end
      n_cmp++; if (seq_q !== e_q[i])     begin n_err++; $display("FAIL seq_q[%0d]: got %h want %h", i, seq_q, e_q[i]); end
      n_cmp++; if (fim_ciclo !== (i == 3)) begin n_err++; $display("FAIL seq_fim[%0d]: got %b want %b", i, fim_ciclo, i == 3); end
    end
    prox = 1'b0;
    step();
    n_cmp++; if (seq_valid !== 1'b0) begin n_err++; $display("FAIL seq_valid_idle: got %b want 0", seq_valid); end
  endtask

  task automatic test_write_read();
    we = 1'b1; w_addr = 4'd7; w_data = 10'h2AA; r_addr = 4'd7;
    step();
    we = 1'b0;
    n_cmp++; if (r_q !== 10'h2AA) begin n_err++; $display("FAIL write_first_read: got %h want 2aa", r_q); end
  endtask

  task automatic test_read_before_write();
    // The sequencer pointer sits at 1 after the 0,1,2,3,0 walk.
    we = 1'b1; w_addr = 4'd1; w_data = 10'h155; prox = 1'b1;
    step();
    we = 1'b0; prox = 1'b0; r_addr = 4'd1;
    n_cmp++; if (seq_q !== 10'h1FB) begin n_err++; $display("FAIL rbw_seq_q: got %h want 1fb", seq_q); end
    n_cmp++; if (seq_idx !== 4'd1)  begin n_err++; $display("FAIL rbw_seq_idx: got %0d want 1", seq_idx); end
    step();
    n_cmp++; if (r_q !== 10'h155)   begin n_err++; $display("FAIL rbw_new_data: got %h want 155", r_q); end
  endtask

  task automatic test_limite_lowered();
    logic [3:0] e_idx;
    // Pointer is at 2, above the new limite of 1: it must run to 15, wrap, then wrap at 1.
    limite = 4'd1;
    prox   = 1'b1;
    for (int k = 0; k < 17; k++) begin
      step();
      e_idx = (k < 14) ? 4'(2 + k) : ((k == 15) ? 4'd1 : 4'd0);
      n_cmp++; if (seq_idx !== e_idx) begin n_err++; $display("FAIL lowered_idx[%0d]: got %0d want %0d", k, seq_idx, e_idx); end
      n_cmp++; if (fim_ciclo !== (k == 15)) begin n_err++; $display("FAIL lowered_fim[%0d]: got %b want %b", k, fim_ciclo, k == 15); end
    end
    prox = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    we = 1'b1; w_addr = 4'd4; w_data = 10'h3FF; r_addr = 4'd4;
    step();
    we = 1'b0;
    n_cmp++; if (r_q !== 10'h3FF) begin n_err++; $display("FAIL overwrite_addr4: got %h want 3ff", r_q); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    we = 1'b1; w_addr = 4'd4; w_data = 10'h0AA; prox = 1'b1;
    n = 0;
    while (ocupado === 1'b1 && n < 40) begin
      step();
      n++;
      if (ocupado === 1'b1) begin
        n_cmp++; if (seq_valid !== 1'b0) begin n_err++; $display("FAIL busy_prox_dropped[%0d]: got %b want 0", n, seq_valid); end
        n_cmp++; if (r_q !== 10'h000)    begin n_err++; $display("FAIL busy_r_q_zero[%0d]: got %h want 000", n, r_q); end
      end
    end
    we = 1'b0; prox = 1'b0;
    n_cmp++; if (n != 16) begin n_err++; $display("FAIL restart_sweep_cycles: got %0d want 16", n); end
    step();
    n_cmp++; if (r_q !== 10'h1C0) begin n_err++; $display("FAIL restored_addr4: got %h want 1c0", r_q); end
    prox = 1'b1;
    step();
    prox = 1'b0;
    n_cmp++; if (seq_idx !== 4'd0 || seq_valid !== 1'b1) begin
      n_err++; $display("FAIL seq_ptr_restart: got idx %0d valid %b want idx 0 valid 1", seq_idx, seq_valid);
    end
    n_cmp++; if (seq_q !== 10'h1FB) begin n_err++; $display("FAIL seq_q_restart: got %h want 1fb", seq_q); end
  endtask

  task automatic test_depth32_wrap();
    int n;
    logic [4:0] e_idx;
    n = 0;
    while (ocupado32 === 1'b1 && n < 80) begin
      step();
      n++;
    end
    n_cmp++; if (ocupado32 !== 1'b0) begin n_err++; $display("FAIL d32_sweep_done: got %b want 0", ocupado32); end
    limite32 = 5'd31;
    prox32   = 1'b1;
    for (int i = 0; i < 33; i++) begin
      step();
      e_idx = 5'(i % 32);
      n_cmp++; if (seq_idx32 !== e_idx) begin n_err++; $display("FAIL d32_idx[%0d]: got %0d want %0d", i, seq_idx32, e_idx); end
      n_cmp++; if (seq_q32 !== def_tbl[i % 16]) begin n_err++; $display("FAIL d32_q[%0d]: got %h want %h", i, seq_q32, def_tbl[i % 16]); end
      n_cmp++; if (fim_ciclo32 !== (i == 31)) begin n_err++; $display("FAIL d32_fim[%0d]: got %b want %b", i, fim_ciclo32, i == 31); end
    end
    prox32 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; prox = 1'b0; w_addr = '0; w_data = '0; r_addr = '0; limite = '0;
    we32 = 1'b0; prox32 = 1'b0; w_addr32 = '0; w_data32 = '0; r_addr32 = '0; limite32 = '0;
    test_reset();
    test_init_sweep();
    test_read_defaults();
    test_sequencer();
    test_write_read();
    test_read_before_write();
    test_limite_lowered();
    test_reset_mid_sweep();
    test_depth32_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/memoria_aster_seq.md
# memoria_aster_seq

Parametrised asteroid spawn-table memory for the AstroGenius game core. It stores packed asteroid entries {x, y, direction}, with one write port and one random-access read port. A built-in sequencer hands entries out one by one on request, wrapping at a programmable limit. Synchronous reset re-runs an init sweep that restores the default spawn pattern, so a new game always starts from the same layout.

## Interface
- X_BITS, 4, width of the x coordinate field
- Y_BITS, 4, width of the y coordinate field
- DIR_BITS, 2, width of the direction field
- DEPTH, 16, number of entries (≥2)
- ADDR_W, 4, address width, clog2(DEPTH); DATA_W = X_BITS+Y_BITS+DIR_BITS, packed as {x, y, dir} with x in the MSBs
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high; restarts the init sweep
- we  in  1  write enable, ignored while ocupado
- w_addr  in  ADDR_W  write address
- w_data  in  DATA_W  write data
- r_addr  in  ADDR_W  random-access read address
- r_q  out  DATA_W  data at the address registered on the previous edge
- prox  in  1  request the next sequenced entry (1-cycle pulse per request)
- limite  in  ADDR_W  last sequenced index before wrap; values ≥DEPTH are treated as DEPTH-1
- seq_q  out  DATA_W  sequenced entry
- seq_idx  out  ADDR_W  index of seq_q
- seq_valid  out  1  one-cycle pulse: seq_q/seq_idx are new
- fim_ciclo  out  1  one-cycle pulse together with seq_valid when seq_idx == limite
- ocupado  out  1  high during the init sweep

## Operation
- FSM states are INIT and IDLE. Reset forces INIT with init_ptr=0 and seq_ptr=0, from any state and at any point of a sweep.
- INIT writes default[init_ptr mod 16] to ram[init_ptr] on each cycle, then increments init_ptr. After writing DEPTH-1 it moves to IDLE.
- INIT ignores we and prox; requests made in INIT are dropped, not queued. In INIT, r_q is forced to 0.
- Default table, index 0..15: 0x1FB, 0x1FB, 0x1FB, 0x01C, 0x1C0, 0x39D, 0x1FB, 0x39D, 0x1FB, 0x1DC, 0x1C2, 0x1C2, 0x01C, 0x01C, 0x1FB, 0x1FB.
  - This is the 10-bit default layout. For other field widths, each field is zero-extended or truncated.
- IDLE write: if we, then ram[w_addr] <= w_data.
- IDLE read: r_addr is registered every cycle and r_q = ram[r_addr_reg]. The read is write-first: after a write to the same address, r_q shows the new data.
- IDLE prox handling:
  - seq_q <= ram[seq_ptr] and seq_idx <= seq_ptr.
  - seq_valid is 1 for one cycle.
  - seq_ptr <= (seq_ptr == eff_limite) ? 0 : seq_ptr+1.
  - fim_ciclo = 1 when the read index equals eff_limite.
  - If we targets seq_ptr in the same cycle, seq_q returns the old data (read-before-write).
- If limite is lowered below seq_ptr, the pointer keeps incrementing until it wraps at DEPTH-1, and then honours the new limite.

## Timing
- Reset values: ocupado=1, seq_valid=0, fim_ciclo=0, seq_q=0, seq_idx=0, r_q=0.
- The init sweep takes DEPTH cycles after reset deasserts. ocupado falls on the DEPTH-th edge; the first accepted we/prox is on the following edge.
- r_q latency is 1 cycle from r_addr. seq_q, seq_idx, seq_valid and fim_ciclo have 1-cycle latency from prox.
- Back-to-back prox is allowed, one entry per cycle.

## Structure
- aster_pkg holds:
  - the field-width defaults;
  - pack/unpack functions for {x, y, dir};
  - the 16-entry default table and a default_entry(i) function.
- The sub-module aster_ram holds the storage array, one write port, a write-first registered-address read (r) and a read-before-write synchronous read (seq).
- memoria_aster_seq holds the FSM, init_ptr, seq_ptr and the wrap logic.

## Test plan
- Reset, then wait until ocupado falls (16 cycles). Read r_addr 0, 3, 5, 9, 10 → r_q = 0x1FB, 0x01C, 0x39D, 0x1DC, 0x1C2.
- limite=3, 5 prox pulses → seq_idx 0, 1, 2, 3, 0. fim_ciclo only on idx 3. seq_q 0x1FB, 0x1FB, 0x1FB, 0x01C, 0x1FB.
- Write 0x2AA to addr 7, read addr 7 on the next cycle → 0x2AA.
- Write 0x155 to seq_ptr's address in the same cycle as prox → seq_q shows the old value. The next full cycle returns 0x155.
- Overwrite addr 4, then assert reset 5 cycles into a new sweep → the sweep restarts from 0. After 16 cycles, addr 4 reads 0x1C0. prox and we are ignored while ocupado.
- DEPTH=32, limite=31: walk 32 prox → entries 16..31 repeat the default table. fim_ciclo on idx 31, then idx 0.
